// File: rtl/hybrid_rows_capture_if.sv
// Result channel of hybrid_rows_capture: one window result per valid/ready handshake.
interface hybrid_rows_capture_if #(
  parameter int CNT_W  = 8,
  parameter int HIST_W = 8
);
  logic              rd_valid;
  logic              rd_ready;
  logic [CNT_W-1:0]  rd_count;
  logic [HIST_W-1:0] rd_hist;
  logic              rd_sat;

  modport master (output rd_valid, rd_count, rd_hist, rd_sat, input rd_ready);
  modport slave  (input rd_valid, rd_count, rd_hist, rd_sat, output rd_ready);
endinterface

// File: rtl/hybrid_rows_capture.sv
// Counts synchronized rising edges of an asynchronous din over fixed windows and
// hands each window's count/history/saturation to a consumer over valid/ready.
module hybrid_rows_capture #(
  parameter int CNT_W  = 8,
  parameter int WIN    = 16,
  parameter int HIST_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  din,
  input  logic                  en,
  input  logic                  clear,
  hybrid_rows_capture_if.master rd,
  output logic                  missed
);
  localparam int WC_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [WC_W-1:0]  LAST    = WC_W'(WIN - 1);
  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {IDLE, SAMPLE, REPORT} state_t;

  state_t             state_q, state_d;
  logic               s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [WC_W-1:0]    win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0]   acc_q, acc_d;
  logic               sat_q, sat_d;
  logic [HIST_W-1:0]  hist_q, hist_d;
  logic               rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0]   rd_count_q, rd_count_d;
  logic [HIST_W-1:0]  rd_hist_q, rd_hist_d;
  logic               rd_sat_q, rd_sat_d;
  logic               missed_q, missed_d;

  logic               edge_w;
  logic               acc_full;
  logic [CNT_W-1:0]   acc_step;
  logic               sat_step;
  logic [HIST_W-1:0]  hist_step;

  assign edge_w    = s2_q & ~s3_q;
  assign acc_full  = (acc_q == ACC_MAX);
  assign acc_step  = (edge_w && !acc_full) ? acc_q + CNT_W'(1) : acc_q;
  assign sat_step  = sat_q | (edge_w & acc_full);
  assign hist_step = HIST_W'({hist_q, s2_q});

  always_comb begin
    // Synchronizer keeps running through clear so no stale sample survives it.
    s1_d       = din;
    s2_d       = s1_q;
    s3_d       = s2_q;
    state_d    = state_q;
    win_cnt_d  = win_cnt_q;
    acc_d      = acc_q;
    sat_d      = sat_q;
    hist_d     = hist_q;
    rd_valid_d = rd_valid_q;
    rd_count_d = rd_count_q;
    rd_hist_d  = rd_hist_q;
    rd_sat_d   = rd_sat_q;
    missed_d   = missed_q;

    if (clear) begin
      state_d    = IDLE;
      win_cnt_d  = '0;
      acc_d      = '0;
      sat_d      = 1'b0;
      hist_d     = '0;
      rd_valid_d = 1'b0;
      rd_count_d = '0;
      rd_hist_d  = '0;
      rd_sat_d   = 1'b0;
      missed_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          win_cnt_d = '0;
          acc_d     = '0;
          sat_d     = 1'b0;
          hist_d    = '0;
          if (en) state_d = SAMPLE;
        end
        SAMPLE: begin
          win_cnt_d = win_cnt_q + WC_W'(1);
          acc_d     = acc_step;
          sat_d     = sat_step;
          hist_d    = hist_step;
          if (win_cnt_q == LAST) begin
            win_cnt_d  = '0;
            rd_valid_d = 1'b1;
            rd_count_d = acc_step;
            rd_hist_d  = hist_step;
            rd_sat_d   = sat_step;
            state_d    = REPORT;
          end
        end
        REPORT: begin
          if (edge_w) missed_d = 1'b1;
          if (rd_valid_q && rd.rd_ready) begin
            rd_valid_d = 1'b0;
            win_cnt_d  = '0;
            acc_d      = '0;
            sat_d      = 1'b0;
            hist_d     = '0;
            state_d    = en ? SAMPLE : IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      win_cnt_q  <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      hist_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_count_q <= '0;
      rd_hist_q  <= '0;
      rd_sat_q   <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      win_cnt_q  <= win_cnt_d;
      acc_q      <= acc_d;
      sat_q      <= sat_d;
      hist_q     <= hist_d;
      rd_valid_q <= rd_valid_d;
      rd_count_q <= rd_count_d;
      rd_hist_q  <= rd_hist_d;
      rd_sat_q   <= rd_sat_d;
      missed_q   <= missed_d;
    end
  end

  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_count = rd_count_q;
  assign rd.rd_hist  = rd_hist_q;
  assign rd.rd_sat   = rd_sat_q;
  assign missed      = missed_q;
endmodule

// File: tb/tb_hybrid_rows_capture.sv
// Randomized bench for hybrid_rows_capture: an 8-bit and a 2-bit counter instance run
// in lockstep and are checked against a window model built from the recorded din samples.
module tb_hybrid_rows_capture;
  localparam int WIN  = 16;
  localparam int HW   = 8;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0;
  logic en = 1'b0;
  logic clear = 1'b0;
  logic rd_ready = 1'b0;
  logic missed8, missed2;

  hybrid_rows_capture_if #(.CNT_W(8), .HIST_W(HW)) rd8 ();
  hybrid_rows_capture_if #(.CNT_W(2), .HIST_W(HW)) rd2 ();
  assign rd8.rd_ready = rd_ready;
  assign rd2.rd_ready = rd_ready;

  hybrid_rows_capture #(.CNT_W(8), .WIN(WIN), .HIST_W(HW)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clear(clear), .rd(rd8), .missed(missed8));
  hybrid_rows_capture #(.CNT_W(2), .WIN(WIN), .HIST_W(HW)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .din(din), .en(en), .clear(clear), .rd(rd2), .missed(missed2));

  always #5 clk = ~clk;

  // samp[t] is the din value seen by rising edge number t.
  int cyc = 0;
  bit samp [MAXC];
  int n_tests = 0;
  int n_fail  = 0;
  bit missed_m = 1'b0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc < MAXC) samp[cyc] = din;
  end

  typedef struct {
    logic v_early, v;
    logic [7:0] c8;
    logic [1:0] c2;
    logic [HW-1:0] h8, h2;
    logic s8, s2;
    int e0;
  } obs_t;

  // A rise of the synchronized input is counted two edges after din is first sampled high.
  function automatic bit edge_at(int t);
    if (t < 3 || t >= MAXC) return 1'b0;
    return samp[t-2] & ~samp[t-3];
  endfunction

  function automatic int edges_in(int a, int b);
    int n = 0;
    for (int t = a; t <= b; t++) n += int'(edge_at(t));
    return n;
  endfunction

  task automatic model_window(input int e0, output logic [7:0] c8, output logic [1:0] c2,
                              output logic [HW-1:0] h, output logic s8, output logic s2);
    int n;
    n  = edges_in(e0 + 1, e0 + WIN);
    c8 = (n > 255) ? 8'd255 : 8'(n);
    s8 = (n > 255);
    c2 = (n > 3) ? 2'd3 : 2'(n);
    s2 = (n > 3);
    for (int k = 0; k < HW; k++) h[k] = samp[e0 + WIN - 2 - k];
  endtask

  task automatic start_idle();
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    missed_m = 1'b0;
  endtask

  // Drives one window's worth of din; called at the negedge following the start edge.
  task automatic run_window(input int mode, output obs_t o);
    o.e0 = cyc;
    for (int i = 1; i <= WIN; i++) begin
      case (mode)
        1:       din = (((i - 1) / 2) % 2) == 0;
        2:       din = (i % 2) == 1;
        3:       din = 1'b1;
        4:       din = (i > WIN - 2) ? 1'b0 : 1'($urandom % 2);
        default: din = 1'($urandom % 2);
      endcase
      if (i == WIN) o.v_early = rd8.rd_valid;
      @(negedge clk);
    end
    o.v  = rd8.rd_valid;
    o.c8 = rd8.rd_count;
    o.c2 = rd2.rd_count;
    o.h8 = rd8.rd_hist;
    o.h2 = rd2.rd_hist;
    o.s8 = rd8.rd_sat;
    o.s2 = rd2.rd_sat;
  endtask

  task automatic handshake(input int delay, input bit en_after, output int h);
    int rs;
    rs = cyc + 1;
    repeat (delay) begin
      din = 1'($urandom % 2);
      @(negedge clk);
    end
    rd_ready = 1'b1;
    en = en_after;
    din = 1'($urandom % 2);
    @(negedge clk);
    h = cyc;
    rd_ready = 1'b0;
    en = 1'b0;
    if (edges_in(rs, h) > 0) missed_m = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (rd8.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", rd8.rd_valid); end
    n_tests++; if (rd8.rd_count !== 8'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", rd8.rd_count); end
    n_tests++; if (rd8.rd_hist !== 8'd0) begin n_fail++; $display("FAIL rst_hist got %h exp 00", rd8.rd_hist); end
    n_tests++; if (rd8.rd_sat !== 1'b0) begin n_fail++; $display("FAIL rst_sat got %b exp 0", rd8.rd_sat); end
    n_tests++; if (missed8 !== 1'b0 || missed2 !== 1'b0) begin n_fail++; $display("FAIL rst_missed got %b%b exp 00", missed8, missed2); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (rd8.rd_valid !== 1'b0 || rd2.rd_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_valid got %b%b exp 00", rd8.rd_valid, rd2.rd_valid); end
    $display("[TB] reset done");
  endtask

  task automatic test_toggle2();
    obs_t o; int h; logic [7:0] ec8; logic [1:0] ec2; logic [HW-1:0] eh; logic es8, es2;
    start_idle();
    run_window(1, o);
    model_window(o.e0, ec8, ec2, eh, es8, es2);
    n_tests++; if (o.v_early !== 1'b0) begin n_fail++; $display("FAIL tog2_valid_early got %b exp 0", o.v_early); end
    n_tests++; if (o.v !== 1'b1) begin n_fail++; $display("FAIL tog2_valid got %b exp 1", o.v); end
    n_tests++; if (o.c8 !== ec8) begin n_fail++; $display("FAIL tog2_count8 got %0d exp %0d", o.c8, ec8); end
    n_tests++; if (o.s8 !== es8) begin n_fail++; $display("FAIL tog2_sat8 got %b exp %b", o.s8, es8); end
    n_tests++; if (o.h8 !== eh) begin n_fail++; $display("FAIL tog2_hist got %h exp %h", o.h8, eh); end
    n_tests++; if (o.c2 !== ec2 || o.s2 !== es2) begin n_fail++; $display("FAIL tog2_cnt2 got %0d/%b exp %0d/%b", o.c2, o.s2, ec2, es2); end
    handshake(2, 1'b0, h);
    n_tests++; if (rd8.rd_valid !== 1'b0) begin n_fail++; $display("FAIL tog2_drop got %b exp 0", rd8.rd_valid); end
    n_tests++; if (missed8 !== missed_m) begin n_fail++; $display("FAIL tog2_missed got %b exp %b", missed8, missed_m); end
    $display("[TB] toggle2 window count=%0d hist=%h", o.c8, o.h8);
  endtask

  task automatic test_saturate();
    obs_t o; int h; logic [7:0] ec8; logic [1:0] ec2; logic [HW-1:0] eh; logic es8, es2;
    din = 1'b0;
    repeat (3) @(negedge clk);
    start_idle();
    run_window(2, o);
    model_window(o.e0, ec8, ec2, eh, es8, es2);
    n_tests++; if (o.c8 !== ec8 || o.s8 !== es8) begin n_fail++; $display("FAIL sat_count8 got %0d/%b exp %0d/%b", o.c8, o.s8, ec8, es8); end
    n_tests++; if (o.c2 !== ec2) begin n_fail++; $display("FAIL sat_count2 got %0d exp %0d", o.c2, ec2); end
    n_tests++; if (o.s2 !== es2) begin n_fail++; $display("FAIL sat_flag2 got %b exp %b", o.s2, es2); end
    n_tests++; if (o.h2 !== eh) begin n_fail++; $display("FAIL sat_hist2 got %h exp %h", o.h2, eh); end
    handshake(0, 1'b0, h);
    $display("[TB] saturate window count8=%0d count2=%0d sat2=%b", o.c8, o.c2, o.s2);
  endtask

  task automatic test_stall_missed();
    obs_t o, o2; int h, rs; bit exp_m; logic [7:0] ec8; logic [1:0] ec2; logic [HW-1:0] eh; logic es8, es2;
    do_clear();
    start_idle();
    run_window(0, o);
    model_window(o.e0, ec8, ec2, eh, es8, es2);
    n_tests++; if (o.c8 !== ec8) begin n_fail++; $display("FAIL stall_count got %0d exp %0d", o.c8, ec8); end
    rs = cyc + 1;
    for (int d = 0; d < 10; d++) begin
      din = (d == 1 || d == 5);
      rd_ready = 1'b0;
      @(negedge clk);
      n_tests++; if (rd8.rd_valid !== 1'b1 || rd8.rd_count !== ec8) begin n_fail++; $display("FAIL stall_hold got %b/%0d exp 1/%0d", rd8.rd_valid, rd8.rd_count, ec8); end
      exp_m = missed_m | (edges_in(rs, cyc) > 0);
      n_tests++; if (missed8 !== exp_m || missed2 !== exp_m) begin n_fail++; $display("FAIL stall_missed got %b%b exp %b", missed8, missed2, exp_m); end
    end
    rd_ready = 1'b1;
    en = 1'b1;
    din = 1'b0;
    @(negedge clk);
    h = cyc;
    rd_ready = 1'b0;
    en = 1'b0;
    if (edges_in(rs, h) > 0) missed_m = 1'b1;
    n_tests++; if (rd8.rd_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drop got %b exp 0", rd8.rd_valid); end
    run_window(0, o2);
    model_window(o2.e0, ec8, ec2, eh, es8, es2);
    n_tests++; if (o2.v_early !== 1'b0 || o2.v !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b%b exp 01", o2.v_early, o2.v); end
    n_tests++; if (o2.c8 !== ec8 || o2.h8 !== eh) begin n_fail++; $display("FAIL b2b_result got %0d/%h exp %0d/%h", o2.c8, o2.h8, ec8, eh); end
    n_tests++; if (o2.c2 !== ec2 || o2.s2 !== es2) begin n_fail++; $display("FAIL b2b_cnt2 got %0d/%b exp %0d/%b", o2.c2, o2.s2, ec2, es2); end
    handshake(1, 1'b0, h);
    $display("[TB] stall then back-to-back window count=%0d missed=%b", o2.c8, missed8);
  endtask

  task automatic test_oneshot_idle();
    obs_t o; int h; logic [7:0] ec8; logic [1:0] ec2; logic [HW-1:0] eh; logic es8, es2;
    do_clear();
    start_idle();
    run_window(4, o);
    model_window(o.e0, ec8, ec2, eh, es8, es2);
    n_tests++; if (o.v !== 1'b1 || o.c8 !== ec8) begin n_fail++; $display("FAIL oneshot_result got %b/%0d exp 1/%0d", o.v, o.c8, ec8); end
    handshake(0, 1'b0, h);
    for (int i = 0; i < WIN + 4; i++) begin
      din = (i % 3) == 0;
      @(negedge clk);
      n_tests++; if (rd8.rd_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b exp 0 at %0d", rd8.rd_valid, i); end
    end
    n_tests++; if (missed8 !== 1'b0 || missed2 !== 1'b0) begin n_fail++; $display("FAIL idle_missed got %b%b exp 00", missed8, missed2); end
    din = 1'b0;
    $display("[TB] one-shot window count=%0d then idle", o.c8);
  endtask

  task automatic test_hold_high();
    obs_t o; int h; logic [7:0] ec8; logic [1:0] ec2; logic [HW-1:0] eh; logic es8, es2;
    do_clear();
    din = 1'b0;
    repeat (3) @(negedge clk);
    start_idle();
    run_window(3, o);
    model_window(o.e0, ec8, ec2, eh, es8, es2);
    n_tests++; if (o.c8 !== ec8) begin n_fail++; $display("FAIL hold_in_count got %0d exp %0d", o.c8, ec8); end
    n_tests++; if (o.h8 !== eh) begin n_fail++; $display("FAIL hold_in_hist got %h exp %h", o.h8, eh); end
    handshake(0, 1'b0, h);
    din = 1'b1;
    repeat (4) @(negedge clk);
    start_idle();
    run_window(3, o);
    model_window(o.e0, ec8, ec2, eh, es8, es2);
    n_tests++; if (o.c8 !== ec8) begin n_fail++; $display("FAIL hold_pre_count got %0d exp %0d", o.c8, ec8); end
    n_tests++; if (o.h8 !== eh) begin n_fail++; $display("FAIL hold_pre_hist got %h exp %h", o.h8, eh); end
    handshake(0, 1'b0, h);
    din = 1'b0;
    $display("[TB] held-high windows checked");
  endtask

  task automatic test_reset_clear();
    obs_t o; int h; logic [7:0] ec8; logic [1:0] ec2; logic [HW-1:0] eh; logic es8, es2;
    start_idle();
    run_window(0, o);
    handshake(0, 1'b0, h);
    din = 1'b0;
    repeat (3) @(negedge clk);
    start_idle();
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (rd8.rd_valid !== 1'b0 || rd8.rd_count !== 8'd0 || rd8.rd_hist !== 8'd0 || rd8.rd_sat !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs got %b/%0d/%h/%b exp 0/0/00/0", rd8.rd_valid, rd8.rd_count, rd8.rd_hist, rd8.rd_sat); end
    n_tests++; if (missed8 !== 1'b0) begin n_fail++; $display("FAIL midrst_missed got %b exp 0", missed8); end
    missed_m = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_idle();
    run_window(0, o);
    model_window(o.e0, ec8, ec2, eh, es8, es2);
    n_tests++; if (o.c8 !== ec8 || o.h8 !== eh) begin n_fail++; $display("FAIL postrst_result got %0d/%h exp %0d/%h", o.c8, o.h8, ec8, eh); end
    n_tests++; if (o.c2 !== ec2 || o.s2 !== es2) begin n_fail++; $display("FAIL postrst_cnt2 got %0d/%b exp %0d/%b", o.c2, o.s2, ec2, es2); end
    din = 1'b1;
    do_clear();
    n_tests++; if (rd8.rd_valid !== 1'b0 || rd8.rd_count !== 8'd0 || rd8.rd_hist !== 8'd0 || rd8.rd_sat !== 1'b0) begin n_fail++; $display("FAIL clear_outputs got %b/%0d/%h/%b exp 0/0/00/0", rd8.rd_valid, rd8.rd_count, rd8.rd_hist, rd8.rd_sat); end
    n_tests++; if (missed8 !== 1'b0 || rd2.rd_count !== 2'd0) begin n_fail++; $display("FAIL clear_misc got %b/%0d exp 0/0", missed8, rd2.rd_count); end
    start_idle();
    run_window(0, o);
    model_window(o.e0, ec8, ec2, eh, es8, es2);
    n_tests++; if (o.c8 !== ec8 || o.h8 !== eh || o.s8 !== es8) begin n_fail++; $display("FAIL postclr_result got %0d/%h/%b exp %0d/%h/%b", o.c8, o.h8, o.s8, ec8, eh, es8); end
    handshake(0, 1'b0, h);
    $display("[TB] reset mid-window and clear in report checked, count=%0d", o.c8);
  endtask

  task automatic test_random();
    obs_t o; int h; bit in_sample; bit en_after;
    logic [7:0] ec8; logic [1:0] ec2; logic [HW-1:0] eh; logic es8, es2;
    in_sample = 1'b0;
    for (int w = 0; w < 8; w++) begin
      if (!in_sample) begin
        repeat ($urandom % 3) begin din = 1'($urandom % 2); @(negedge clk); end
        start_idle();
      end
      run_window(0, o);
      model_window(o.e0, ec8, ec2, eh, es8, es2);
      n_tests++; if (o.v_early !== 1'b0 || o.v !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_valid got %b%b exp 01", w, o.v_early, o.v); end
      n_tests++; if (o.c8 !== ec8 || o.s8 !== es8) begin n_fail++; $display("FAIL rnd%0d_count8 got %0d/%b exp %0d/%b", w, o.c8, o.s8, ec8, es8); end
      n_tests++; if (o.h8 !== eh || o.h2 !== eh) begin n_fail++; $display("FAIL rnd%0d_hist got %h/%h exp %h", w, o.h8, o.h2, eh); end
      n_tests++; if (o.c2 !== ec2 || o.s2 !== es2) begin n_fail++; $display("FAIL rnd%0d_count2 got %0d/%b exp %0d/%b", w, o.c2, o.s2, ec2, es2); end
      en_after = 1'($urandom % 2);
      handshake(int'($urandom % 4), en_after, h);
      in_sample = en_after;
      n_tests++; if (rd8.rd_valid !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_drop got %b exp 0", w, rd8.rd_valid); end
      n_tests++; if (missed8 !== missed_m || missed2 !== missed_m) begin n_fail++; $display("FAIL rnd%0d_missed got %b%b exp %b", w, missed8, missed2, missed_m); end
      $display("[TB] random window %0d count8=%0d count2=%0d hist=%h next_en=%b", w, o.c8, o.c2, o.h8, en_after);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_toggle2();
    test_saturate();
    test_stall_missed();
    test_oneshot_idle();
    test_hold_high();
    test_reset_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hybrid_rows_capture.md
HYBRID_ROWS_CAPTURE -- requirements
Module: hybrid_rows_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 8, edge-count width.
REQ-002 SHALL have parameter WIN, default 16, sample-window length in clk cycles (range 2..2^16).
REQ-003 SHALL have parameter HIST_W, default 8, sample-history depth in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port din  input  1  asynchronous result bit from the upstream hybrid-row stage ("out").
REQ-007 SHALL have port en  input  1  window enable, synchronous.
REQ-008 SHALL have port clear  input  1  synchronous clear, highest priority after reset.
REQ-009 SHALL have port rd_valid  output  1  window result available.
REQ-010 SHALL have port rd_ready  input  1  consumer accepts result.
REQ-011 SHALL have port rd_count  output  CNT_W  rising edges of din in the last window.
REQ-012 SHALL have port rd_hist  output  HIST_W  last HIST_W synchronized samples of the window, bit 0 newest.
REQ-013 SHALL have port rd_sat  output  1  rd_count saturated during the window.
REQ-014 SHALL have port missed  output  1  sticky: edge occurred while in REPORT.

Function
REQ-015 SHALL pass din through a two-flop synchronizer (s1, s2) plus a third delay flop s3; edge = s2 & ~s3.
REQ-016 SHALL produce edge high exactly in the third cycle after the clk edge that first samples din=1 (s1 at k, s2 at k+1, edge during cycle k+2).
REQ-017 SHALL implement FSM states IDLE, SAMPLE, REPORT.
REQ-018 SHALL in IDLE: hold win_cnt=0 and acc=0; go to SAMPLE on the clk edge where en=1.
REQ-019 SHALL in SAMPLE: increment win_cnt each cycle; acc += edge; shift s2 into hist at bit 0.
REQ-020 SHALL saturate acc at 2^CNT_W-1 and set an internal sat flag; no wrap-around.
REQ-021 SHALL on the cycle with win_cnt=WIN-1 include that cycle's edge and sample, latch acc/hist/sat into rd_count/rd_hist/rd_sat, and go to REPORT.
REQ-022 SHALL ignore en deasserting mid-SAMPLE; the window always completes.
REQ-023 SHALL in REPORT: drive rd_valid=1 with rd_count, rd_hist and rd_sat stable until handshake.
REQ-024 SHALL treat the handshake as rd_valid & rd_ready at a clk edge; on it, drop rd_valid next cycle, clear acc, win_cnt and sat, and go to SAMPLE if en=1, else IDLE.
REQ-025 SHALL drop edges that occur in REPORT or IDLE (not counted) and set missed=1 for any edge in REPORT.
REQ-026 SHALL keep missed set until clear or reset.
REQ-027 SHALL permit rd_ready high before rd_valid; no combinational path from rd_ready to rd_valid.
REQ-028 SHALL on clear=1: go to IDLE next cycle, zero all outputs and counters, ignore en and rd_ready that cycle, and keep synchronizer flops running.

Reset
REQ-029 SHALL on rst_n=0 asynchronously set state=IDLE and s1=s2=s3=0.
REQ-030 SHALL on rst_n=0 set rd_valid=0, rd_count=0, rd_hist=0, rd_sat=0, missed=0 and clear internal counters.
REQ-031 SHALL on rst_n=0 mid-SAMPLE or mid-REPORT discard the partial result.
REQ-032 SHALL leave reset deassertion synchronized externally; the first active edge after release is a normal IDLE cycle.

Verification
REQ-033 SHALL cover: en=1; din toggles 0->1->0 every 2 cycles, starting at window start -> rd_valid after 16 SAMPLE cycles, rd_count=4 (first edge lands at window cycle 2 via synchronizer), rd_sat=0.
REQ-034 SHALL cover: CNT_W=2, WIN=16, din toggling every cycle -> rd_count=3, rd_sat=1.
REQ-035 SHALL cover: rd_ready=0 for 10 cycles in REPORT while din pulses twice -> rd_valid stays 1, rd_count unchanged, missed=1 after the first pulse; rd_ready=1 -> rd_valid=0 next cycle, new window starts.
REQ-036 SHALL cover: en=1 for one cycle then 0 -> one full window, then IDLE after handshake; din pulses in IDLE leave missed=0.
REQ-037 SHALL cover: din held 1 for the whole window -> rd_hist=8'hFF, rd_count=1 if the rise falls inside the window, else 0.
REQ-038 SHALL cover: rst_n low at window cycle 7, then clear asserted during REPORT -> all outputs 0 within the same or next clk edge; the next window counts from 0.
